// File: rtl/lc4_div_pkg.sv
// Shared definitions for the LC4 sequential divide/modulo unit.
package lc4_div_pkg;

  localparam int DEFAULT_WIDTH = 16;

  // Quotient and remainder reported when the divisor is zero
  localparam int DIV0_RESULT = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/lc4_div_seq_if.sv
// Start/busy/done handshake and operand/result bus of the divide unit.
interface lc4_div_seq_if
  import lc4_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             i_start;
  logic [WIDTH-1:0] i_dividend;
  logic [WIDTH-1:0] i_divisor;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_quotient;
  logic [WIDTH-1:0] o_remainder;

  // Requester side (execute stage)
  modport master (
    output i_start, i_dividend, i_divisor,
    input  o_busy, o_done, o_quotient, o_remainder
  );

  // Divider side
  modport slave (
    input  i_start, i_dividend, i_divisor,
    output o_busy, o_done, o_quotient, o_remainder
  );

endinterface

// File: rtl/lc4_div_one_iter.sv
// One combinational restoring-division step: shift in the next dividend
// bit, try subtracting the divisor, keep the difference if it fits.
module lc4_div_one_iter
  import lc4_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] dvd_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic [WIDTH-1:0] quo_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] dvd_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH-1:0] trial;
  logic [WIDTH:0]   diff;
  logic             fits;
  logic             unusedMsbs;

  // The remainder stays below the divisor, so its top bit is zero whenever
  // it is shifted; the quotient top bit simply falls off the shift.
  assign unusedMsbs = rem_i[WIDTH-1] ^ quo_i[WIDTH-1];

  assign trial = {rem_i[WIDTH-2:0], dvd_i[WIDTH-1]};
  assign diff  = {1'b0, trial} - {1'b0, divisor_i};
  assign fits  = ~diff[WIDTH];

  assign rem_o = fits ? diff[WIDTH-1:0] : trial;
  assign quo_o = {quo_i[WIDTH-2:0], fits};
  assign dvd_o = {dvd_i[WIDTH-2:0], 1'b0};

endmodule

// File: rtl/lc4_div_seq.sv
// Multi-cycle unsigned divide/modulo: one restoring step per cycle for
// WIDTH cycles, results held from the done pulse until the next start.
module lc4_div_seq
  import lc4_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 4
) (
  input  logic          clk,
  input  logic          rst,
  lc4_div_seq_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] DIV0_VAL = WIDTH'(DIV0_RESULT);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvd_q, divisor_q;
  logic [WIDTH-1:0] rem_d, quo_d, dvd_d;

  lc4_div_one_iter #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .dvd_i     (dvd_q),
    .divisor_i (divisor_q),
    .quo_i     (quo_q),
    .rem_o     (rem_d),
    .dvd_o     (dvd_d),
    .quo_o     (quo_d)
  );

  // Sequencer: accept a start in IDLE/DONE, iterate WIDTH times, then pulse DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvd_q     <= '0;
      divisor_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.i_start) begin
            cnt_q <= '0;
            if (bus.i_divisor == '0) begin
              quo_q     <= DIV0_VAL;
              rem_q     <= DIV0_VAL;
              dvd_q     <= '0;
              divisor_q <= '0;
              state_q   <= ST_DONE;
            end else begin
              quo_q     <= '0;
              rem_q     <= '0;
              dvd_q     <= bus.i_dividend;
              divisor_q <= bus.i_divisor;
              state_q   <= ST_ITER;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ITER: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          dvd_q <= dvd_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_q <= ST_DONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_busy      = (state_q == ST_ITER);
  assign bus.o_done      = (state_q == ST_DONE);
  assign bus.o_quotient  = quo_q;
  assign bus.o_remainder = rem_q;

endmodule

// File: tb/tb_lc4_div_seq.sv
// Randomized and directed bench for lc4_div_seq against an arithmetic model.
module tb_lc4_div_seq;

  logic clk;
  logic rst;
  int   totalChecks = 0;
  int   badChecks   = 0;

  lc4_div_seq_if #(.WIDTH(16)) bus ();

  lc4_div_seq #(.WIDTH(16), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expectation
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               tag, observed, observed, expected, expected, $time);
    end
  endtask

  // Reference: plain integer division with zero results for a zero divisor
  function automatic logic [31:0] refDiv(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] q, r;
    if (b == 16'd0) begin
      q = 16'd0;
      r = 16'd0;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  // Present a start for one cycle from a falling edge; scramble operands afterwards
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b);
    bus.i_start    = 1'b1;
    bus.i_dividend = a;
    bus.i_divisor  = b;
    @(negedge clk);
    bus.i_start    = 1'b0;
    bus.i_dividend = 16'($urandom);
    bus.i_divisor  = 16'($urandom);
  endtask

  // Wait (bounded) for done, optionally pulsing a stray start mid-operation
  task automatic waitDone(input logic [15:0] a, input logic [15:0] b, input int injectAt);
    int          cycles     = 0;
    int          busyCycles = 0;
    int          expLat;
    logic [31:0] expQr;
    expLat = (b == 16'd0) ? 0 : 16;
    expQr  = refDiv(a, b);
    while (!bus.o_done && cycles < 40) begin
      if (bus.o_busy) busyCycles++;
      if (cycles == injectAt) begin
        bus.i_start    = 1'b1;
        bus.i_dividend = 16'd50;
        bus.i_divisor  = 16'd3;
      end
      @(negedge clk);
      bus.i_start = 1'b0;
      cycles++;
    end
    checkOutput("done", 32'(bus.o_done), 32'd1);
    checkOutput("latency", 32'(cycles), 32'(expLat));
    checkOutput("busyCycles", 32'(busyCycles), 32'(expLat));
    checkOutput("busyInDone", 32'(bus.o_busy), 32'd0);
    checkOutput("quotient", 32'(bus.o_quotient), 32'(expQr[31:16]));
    checkOutput("remainder", 32'(bus.o_remainder), 32'(expQr[15:0]));
  endtask

  // One idle cycle after done: pulse gone, results still held
  task automatic checkHold(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] expQr;
    expQr = refDiv(a, b);
    @(negedge clk);
    checkOutput("holdDone", 32'(bus.o_done), 32'd0);
    checkOutput("holdBusy", 32'(bus.o_busy), 32'd0);
    checkOutput("holdQuotient", 32'(bus.o_quotient), 32'(expQr[31:16]));
    checkOutput("holdRemainder", 32'(bus.o_remainder), 32'(expQr[15:0]));
  endtask

  task automatic runOp(input logic [15:0] a, input logic [15:0] b);
    applyStimulus(a, b);
    waitDone(a, b, -1);
    checkHold(a, b);
  endtask

  // Main sequence: reset, directed cases, then randomized operations
  initial begin
    logic [15:0] a, b;
    rst            = 1'b1;
    bus.i_start    = 1'b0;
    bus.i_dividend = 16'd0;
    bus.i_divisor  = 16'd0;
    repeat (2) @(negedge clk);
    checkOutput("rstBusy", 32'(bus.o_busy), 32'd0);
    checkOutput("rstDone", 32'(bus.o_done), 32'd0);
    checkOutput("rstQuotient", 32'(bus.o_quotient), 32'd0);
    checkOutput("rstRemainder", 32'(bus.o_remainder), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    runOp(16'd100, 16'd7);
    runOp(16'hFFFF, 16'd1);
    runOp(16'hFFFF, 16'hFFFF);
    runOp(16'd5, 16'd9);
    runOp(16'd1234, 16'd0);

    // Stray start during iteration cycle 5 must be ignored
    applyStimulus(16'd100, 16'd7);
    waitDone(16'd100, 16'd7, 5);
    checkHold(16'd100, 16'd7);

    // Back-to-back: new start presented during the done cycle
    applyStimulus(16'd100, 16'd7);
    waitDone(16'd100, 16'd7, -1);
    applyStimulus(16'd200, 16'd9);
    waitDone(16'd200, 16'd9, -1);
    checkHold(16'd200, 16'd9);

    // Reset in iteration cycle 8 abandons the operation
    applyStimulus(16'd100, 16'd7);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midRstBusy", 32'(bus.o_busy), 32'd0);
    checkOutput("midRstDone", 32'(bus.o_done), 32'd0);
    checkOutput("midRstQuotient", 32'(bus.o_quotient), 32'd0);
    checkOutput("midRstRemainder", 32'(bus.o_remainder), 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.o_done) checkOutput("noDoneAfterReset", 32'(bus.o_done), 32'd0);
    end
    checkOutput("idleAfterReset", 32'(bus.o_busy), 32'd0);
    runOp(16'd9, 16'd2);

    // Randomized operands, mixing zero/small/full-range divisors and back-to-back starts
    for (int n = 0; n < 40; n++) begin
      a = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       b = 16'd0;
        1:       b = 16'($urandom_range(1, 15));
        2:       b = a;
        default: b = 16'($urandom);
      endcase
      if ($urandom_range(0, 4) == 0) a = 16'($urandom_range(0, 20));
      applyStimulus(a, b);
      waitDone(a, b, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1);
      if ($urandom_range(0, 1) == 1) checkHold(a, b);
    end

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/lc4_div_seq.md
Name: lc4_div_seq

Overview:
Multi-cycle unsigned 16-bit divide/modulo unit for the LC4 datapath. It replaces a fully combinational DIV/MOD path with a sequencer that iterates a single one-bit restoring-division stage WIDTH times. It accepts one operation at a time with a start/busy/done handshake and holds its results until the next accepted start. The ALU/execute stage uses it for the DIV and MOD instructions and stalls on o_busy.

Parameters:
WIDTH, 16, operand, quotient and remainder width; iteration count equals WIDTH.
CNT_W, 4, width of the iteration counter; must satisfy 2^CNT_W >= WIDTH.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
i_start  input  1  request a new operation; sampled only in IDLE or DONE.
i_dividend  input  WIDTH  unsigned dividend; sampled on the accepting edge only.
i_divisor  input  WIDTH  unsigned divisor; sampled on the accepting edge only.
o_busy  output  1  high while in ITER.
o_done  output  1  one-cycle pulse; results are valid in this cycle and held afterwards.
o_quotient  output  WIDTH  registered quotient.
o_remainder  output  WIDTH  registered remainder.

Behaviour:
- Reset: state=IDLE, counter=0, all internal registers 0, o_busy=0, o_done=0, o_quotient=0, o_remainder=0.
- Reset mid-operation takes priority over everything else: the operation is abandoned, there is no done pulse, and outputs go to 0.
- States: IDLE, ITER, DONE. Encode them as constants in the package.
- IDLE:
  - i_start=1 and divisor!=0: latch dividend into a shift register, divisor into a register; rem=0, quo=0, cnt=0; go to ITER.
  - i_start=1 and divisor==0: set quo=0, rem=0; go to DONE (divide-by-zero convention: both results 0, latency 1).
  - Otherwise stay in IDLE.
- ITER, one iteration per cycle:
  - t = {rem[WIDTH-2:0], dvd[WIDTH-1]}
  - if t >= divisor: rem = t - divisor, quo = {quo[WIDTH-2:0], 1}
  - else: rem = t, quo = {quo[WIDTH-2:0], 0}
  - dvd <<= 1; cnt++.
  - On the iteration where cnt==WIDTH-1, go to DONE.
  - The comparison is a WIDTH+1-bit unsigned subtract; no signed arithmetic anywhere.
- DONE:
  - o_done=1 for exactly this cycle; o_quotient/o_remainder show the final values.
  - Next state is IDLE, or the start path as in IDLE if i_start=1. Back-to-back operations are legal.
- Latency: start accepted at edge E0 puts the unit in ITER. Iterations occur at edges E1..E16 (WIDTH=16), and o_done is high in the cycle following E16. The divisor==0 case gives o_done in the cycle after E0.
- i_start while in ITER is ignored; the operands are not re-sampled.
- Operand inputs may change freely after the accepting edge.
- o_quotient and o_remainder are held stable from DONE until the next accepting edge. They are driven directly from the quo/rem registers; there is no combinational path from the inputs.
- o_busy = (state==ITER); o_done = (state==DONE). Both are purely state-decoded.

Decomposition:
- Package lc4_div_pkg holds: state encodings (IDLE/ITER/DONE), default WIDTH, and the divide-by-zero result constant (0).
- One sub-module is natural: lc4_div_one_iter, a combinational single restoring step.
  - Inputs: rem, dvd, divisor, quo.
  - Outputs: next rem, dvd, quo.
  - The controller instantiates it once and registers its outputs.

Test Plan:
- Start 100/7 in IDLE -> o_busy high for 16 cycles; o_done pulses 16 cycles after the accepting edge with q=14, r=2; outputs hold afterwards.
- Start 0xFFFF/1, then 0xFFFF/0xFFFF, then 5/9 -> (0xFFFF,0), (1,0), (0,5).
- Start 1234/0 -> o_done in the next cycle, q=0, r=0, o_busy never asserted.
- Start 100/7; pulse i_start with 50/3 in iteration cycle 5 -> ignored; the result is still 14/2 at the same cycle.
- Assert i_start with 200/9 during the DONE cycle of 100/7 -> o_done for 14/2, then immediately ITER; 16 cycles later q=22, r=2.
- Assert rst in iteration cycle 8 of 100/7 -> next cycle IDLE, outputs 0, no o_done; a subsequent 9/2 returns q=4, r=1.
